// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 block loader: FSM encoding, block size
// and UART-derived timing defaults.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam int BLK_BYTES            = 64;
  localparam int CLKS_PER_BIT         = 868;
  localparam int DEFAULT_TIMEOUT_CLKS = 20 * CLKS_PER_BIT;

  // MSB position of byte lane i in the big-endian 512-bit block
  function automatic int byte_msb(input int i);
    return 511 - 8 * i;
  endfunction

endpackage

// File: rtl/sha256_idle_timer.sv
// Idle-gap counter: counts enabled cycles since the last clear and emits a
// single-cycle expire strobe when the gap reaches TIMEOUT_CLKS.
module sha256_idle_timer
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = ($clog2(TIMEOUT_CLKS) > 17) ? $clog2(TIMEOUT_CLKS) : 17;

  logic [CW-1:0] cnt;

  // clear wins over expiry so a byte arriving on the last idle cycle is kept
  assign expire = enable && !clear && (cnt == CW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sha256_block_loader.sv
// Collects UART bytes into 64-byte big-endian SHA-256 message blocks and
// hands each complete block to the core with a valid/ready handshake.
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
  parameter int BLK_BYTES    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [511:0] blk_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [6:0]   byte_cnt,
  output logic         ovf,
  output logic         tout,
  output state_t       fsm_state
);

  // Handshake: a block transfers on any rising edge where blk_valid and
  // blk_ready are both high; blk_valid and blk_data hold until then.

  localparam logic [6:0] LAST_IDX = 7'(BLK_BYTES - 1);

  state_t     state, state_n;
  logic [6:0] cnt_n;
  logic       valid_n, ovf_n, tout_n;
  logic       wr_en;
  logic [5:0] wr_idx;
  logic       expire;

  assign fsm_state = state;

  sha256_idle_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (rx_valid || (state != ST_FILL)),
    .enable (state == ST_FILL),
    .expire (expire)
  );

  always_comb begin
    state_n = state;
    cnt_n   = byte_cnt;
    valid_n = blk_valid;
    ovf_n   = 1'b0;
    tout_n  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = byte_cnt[5:0];
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          wr_en   = 1'b1;
          wr_idx  = 6'd0;
          cnt_n   = 7'd1;
          state_n = ST_FILL;
        end
      end
      ST_FILL: begin
        if (rx_valid) begin
          wr_en = 1'b1;
          cnt_n = byte_cnt + 7'd1;
          if (byte_cnt == LAST_IDX) begin
            valid_n = 1'b1;
            state_n = ST_FULL;
          end
        end else if (expire) begin
          cnt_n   = 7'd0;
          tout_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (blk_ready) begin
          valid_n = 1'b0;
          if (rx_valid) begin
            // the incoming byte starts the next block rather than being dropped
            wr_en   = 1'b1;
            wr_idx  = 6'd0;
            cnt_n   = 7'd1;
            state_n = ST_FILL;
          end else begin
            cnt_n   = 7'd0;
            state_n = ST_IDLE;
          end
        end else if (rx_valid) begin
          ovf_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 7'd0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= 7'd0;
      blk_valid <= 1'b0;
      ovf       <= 1'b0;
      tout      <= 1'b0;
    end else begin
      state     <= state_n;
      byte_cnt  <= cnt_n;
      blk_valid <= valid_n;
      ovf       <= ovf_n;
      tout      <= tout_n;
    end
  end

  for (genvar i = 0; i < 64; i++) begin : g_byte
    logic [7:0] byte_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        byte_q <= 8'h00;
      end else if (wr_en && (wr_idx == 6'(i))) begin
        byte_q <= rx_data;
      end
    end
    assign blk_data[511-8*i -: 8] = byte_q;
  end

endmodule
